dmem_bus_bridge: RTL
====================

// Module: dmem_bus_bridge
// PURPOSE
// - Sits between the CPU data-memory port (d_mem_addr/d_mem_wdata/d_mem_wen/d_mem_rdata, single-cycle)
//   and a multi-cycle valid/ready data bus.
// - Turns each load/store into one bus transaction and holds the pipeline with cpu_stall until it completes.
// - Checks alignment, returns read data in a register, and reports bus errors and timeouts.
// PARAMETERS
// - ADDR_W       32   address width
// - DATA_W       32   data width (fixed 32 for RV32)
// - TIMEOUT_CYC  255  max cycles in WAIT_RSP before forced error; 0 = timeout disabled
// - CNT_W        8    timeout counter width; TIMEOUT_CYC must fit in it
// PORTS
// - clk            in   1   clock; all state updates on the rising edge
// - rst            in   1   asynchronous, active-high reset
// - cpu_addr       in   32  access address (ALU result, MEM stage)
// - cpu_wdata      in   32  store data
// - cpu_wen        in   4   byte enables; nonzero = store
// - cpu_read       in   1   load request
// - cpu_rdata      out  32  load data; valid only in the DONE cycle
// - cpu_stall      out  1   freeze PC, IF/ID, ID/EX and EX/MEM while high
// - cpu_err        out  1   one-cycle pulse in DONE: misaligned, bus error or timeout
// - bus_req_valid  out  1   request valid
// - bus_req_ready  in   1   request accepted when valid && ready
// - bus_req_addr   out  32  registered address; bits [1:0] forced to 00
// - bus_req_we     out  1   1 = write
// - bus_req_wstrb  out  4   registered byte enables
// - bus_req_wdata  out  32  registered store data
// - bus_rsp_valid  in   1   response valid (reads and writes); no ready, always accepted
// - bus_rsp_rdata  in   32  read data
// - bus_rsp_err    in   1   slave error
// BEHAVIOUR
// - Reset: state=IDLE; all outputs 0; internal regs and counter cleared. Assert and release are asynchronous.
// - An access exists when cpu_read || cpu_wen != 0. The CPU holds its inputs stable while cpu_stall=1.
// - cpu_stall = (state==IDLE && access) || state==REQ || state==WAIT_RSP. This is combinational;
//   DONE and IDLE without an access give 0.
// - IDLE: on an access, latch addr/wdata/wen/we and run the alignment check.
//   - Legal: go to REQ.
//   - Illegal: go to DONE with err=1 and rdata=0; no bus traffic.
// - Alignment rules:
//   - Load: addr[1:0]=00.
//   - Store: wen must be one of 0001,0010,0100,1000,0011,1100,1111 (0011/1100 = aligned half, 1111 = word).
//   - cpu_read together with wen!=0 is illegal.
// - REQ: bus_req_valid=1 with the latched fields held stable. On bus_req_ready go to WAIT_RSP.
//   There is no timeout in REQ.
// - WAIT_RSP: counter increments every cycle. A response is accepted no earlier than the cycle after acceptance.
//   - bus_rsp_valid: latch rdata (forced 0 for writes) and err=bus_rsp_err, then go to DONE.
//   - counter == TIMEOUT_CYC-1 with TIMEOUT_CYC != 0: err=1, rdata=0, go to DONE.
//   - A response in the same cycle as the timeout wins over the timeout.
// - DONE: exactly one cycle. cpu_rdata = latched data, cpu_err = latched err. New CPU inputs are not
//   sampled; go to IDLE.
// - Latency: best case is 3 stall cycles (IDLE, REQ, WAIT_RSP); the CPU advances at the end of DONE.
//   Back-to-back accesses: the next access is seen in the IDLE cycle after DONE.
// - bus_rsp_valid outside WAIT_RSP (e.g. a late response after reset or timeout) is ignored.
// - rst mid-transaction: bus_req_valid drops at once and the transaction is abandoned. No retry.
// STRUCTURE
// - Shared header dmem_bus_defs.vh holds:
//   - state encodings IDLE=2'd0, REQ=2'd1, WAIT_RSP=2'd2, DONE=2'd3;
//   - legal WSTRB_* constants.
// - Sub-module dmem_align_check (combinational): inputs addr[1:0], wen, read; output misaligned.
// - Top of the block: FSM, request/response registers, timeout counter.
// TESTING
// - Load, slave ready=1, rsp 1 cycle later:
//   addr=0x100, rdata=0xDEADBEEF -> stall high for 3 cycles, DONE shows cpu_rdata=0xDEADBEEF, cpu_err=0.
// - Store wen=1100, addr=0x202, wdata=0x12345678, ready delayed 4 cycles
//   -> bus_req_addr=0x200, wstrb=1100, valid held stable 4 cycles, we=1.
// - Misaligned load addr=0x103 -> no bus_req_valid, DONE the next cycle with cpu_err=1 and cpu_rdata=0.
//   Same result for store wen=0101.
// - Timeout with TIMEOUT_CYC=4 and no rsp -> cpu_err=1 in DONE after 4 WAIT_RSP cycles.
//   A late rsp_valid arriving in IDLE is ignored.
// - bus_rsp_err=1 on a load -> cpu_err=1 and cpu_rdata=rsp data masked to 0.
//   Back-to-back load then store both complete in order.
// - rst pulsed during WAIT_RSP -> immediate IDLE with all outputs 0; the next access runs normally.

Source files
------------

// File: rtl/dmem_bus_bridge_pkg.sv
// ---------------------------------------------------------------------------
// dmem_bus_bridge_pkg
// Shared definitions for the CPU data-memory to valid/ready bus bridge.
// Contents:
//   state_t      - bridge FSM state encoding (IDLE, REQ, WAIT_RSP, DONE)
//   WSTRB_*      - the byte-enable patterns a store may legally use
//   wstrb_legal  - true when a store byte-enable pattern is a naturally
//                  aligned byte, half-word or word
// ---------------------------------------------------------------------------
package dmem_bus_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2,
    DONE     = 2'd3
  } state_t;

  localparam logic [3:0] WSTRB_B0 = 4'b0001;
  localparam logic [3:0] WSTRB_B1 = 4'b0010;
  localparam logic [3:0] WSTRB_B2 = 4'b0100;
  localparam logic [3:0] WSTRB_B3 = 4'b1000;
  localparam logic [3:0] WSTRB_H0 = 4'b0011;
  localparam logic [3:0] WSTRB_H1 = 4'b1100;
  localparam logic [3:0] WSTRB_W  = 4'b1111;

  function automatic logic wstrb_legal(input logic [3:0] wstrb);
    logic ok;
    ok = 1'b0;
    case (wstrb)
      WSTRB_B0, WSTRB_B1, WSTRB_B2, WSTRB_B3,
      WSTRB_H0, WSTRB_H1, WSTRB_W: ok = 1'b1;
      default:                     ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dmem_align_check.sv
// ---------------------------------------------------------------------------
// dmem_align_check
// Combinational legality check for one CPU data access.
// Ports:
//   addr        in  2  low address bits of the access
//   wen         in  4  store byte enables (nonzero = store)
//   read        in  1  load request
//   misaligned  out 1  access may not be sent to the bus
// Loads must be word aligned. Stores are judged by their byte-enable
// pattern alone, since the CPU already places the lane from the address.
// A load and a store requested together is treated as illegal.
// ---------------------------------------------------------------------------
module dmem_align_check
  import dmem_bus_bridge_pkg::*;
(
  input  logic [1:0] addr,
  input  logic [3:0] wen,
  input  logic       read,
  output logic       misaligned
);

  always_comb begin
    misaligned = 1'b0;
    if (read && (wen != 4'b0000)) begin
      misaligned = 1'b1;
    end else if (read) begin
      misaligned = (addr != 2'b00);
    end else if (wen != 4'b0000) begin
      misaligned = !wstrb_legal(wen);
    end
  end

endmodule

// File: rtl/dmem_bus_bridge.sv
// ---------------------------------------------------------------------------
// dmem_bus_bridge
// Converts single-cycle CPU loads/stores into one valid/ready bus
// transaction each, stalling the pipeline until the response returns.
// Parameters:
//   ADDR_W       address width
//   DATA_W       data width (32 for RV32)
//   TIMEOUT_CYC  cycles allowed in WAIT_RSP before a forced error, 0 = never
//   CNT_W        width of the response timeout counter
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   cpu_addr        in   access address
//   cpu_wdata       in   store data
//   cpu_wen         in   store byte enables, nonzero = store
//   cpu_read        in   load request
//   cpu_rdata       out  load data, valid only in the DONE cycle
//   cpu_stall       out  hold the CPU pipeline while high
//   cpu_err         out  one-cycle error pulse in DONE
//   bus_req_valid   out  request valid
//   bus_req_ready   in   request accepted when valid && ready
//   bus_req_addr    out  word-aligned request address
//   bus_req_we      out  1 = write
//   bus_req_wstrb   out  request byte enables
//   bus_req_wdata   out  request write data
//   bus_rsp_valid   in   response valid, always accepted
//   bus_rsp_rdata   in   response read data
//   bus_rsp_err     in   slave error
// ---------------------------------------------------------------------------
module dmem_bus_bridge
  import dmem_bus_bridge_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255,
  parameter int CNT_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic [3:0]        cpu_wen,
  input  logic              cpu_read,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  output logic              cpu_err,
  output logic              bus_req_valid,
  input  logic              bus_req_ready,
  output logic [ADDR_W-1:0] bus_req_addr,
  output logic              bus_req_we,
  output logic [3:0]        bus_req_wstrb,
  output logic [DATA_W-1:0] bus_req_wdata,
  input  logic              bus_rsp_valid,
  input  logic [DATA_W-1:0] bus_rsp_rdata,
  input  logic              bus_rsp_err
);

  localparam logic             TO_EN   = (TIMEOUT_CYC != 0);
  // With the timeout disabled this wraps to all-ones, but TO_EN masks it.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_t              state;
  state_t              next_state;
  logic                access;
  logic                misaligned;
  logic                timeout_hit;

  logic [ADDR_W-1:2]   req_addr;
  logic [DATA_W-1:0]   req_wdata;
  logic [3:0]          req_wstrb;
  logic                req_we;
  logic [DATA_W-1:0]   rsp_data;
  logic                rsp_err;
  logic [CNT_W-1:0]    wait_cnt;

  assign access      = cpu_read || (cpu_wen != 4'b0000);
  assign timeout_hit = TO_EN && (wait_cnt == TO_LAST);

  dmem_align_check u_align (
    .addr       (cpu_addr[1:0]),
    .wen        (cpu_wen),
    .read       (cpu_read),
    .misaligned (misaligned)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (access) begin
          next_state = misaligned ? DONE : REQ;
        end
      end
      REQ: begin
        if (bus_req_ready) begin
          next_state = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        // A response arriving on the timeout cycle still completes normally;
        // the data path below gives it priority as well.
        if (bus_rsp_valid || timeout_hit) begin
          next_state = DONE;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Request capture, response capture and timeout counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_addr  <= '0;
      req_wdata <= '0;
      req_wstrb <= '0;
      req_we    <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      wait_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (access) begin
            req_addr  <= cpu_addr[ADDR_W-1:2];
            req_wdata <= cpu_wdata;
            req_wstrb <= cpu_wen;
            req_we    <= (cpu_wen != 4'b0000);
            rsp_data  <= '0;
            rsp_err   <= misaligned;
            wait_cnt  <= '0;
          end
        end
        REQ: begin
          if (bus_req_ready) begin
            wait_cnt <= '0;
          end
        end
        WAIT_RSP: begin
          wait_cnt <= wait_cnt + CNT_W'(1);
          if (bus_rsp_valid) begin
            // Writes return no data, and errored reads never expose slave data.
            rsp_data <= (req_we || bus_rsp_err) ? '0 : bus_rsp_rdata;
            rsp_err  <= bus_rsp_err;
          end else if (timeout_hit) begin
            rsp_data <= '0;
            rsp_err  <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign cpu_stall     = ((state == IDLE) && access) || (state == REQ) || (state == WAIT_RSP);
  assign cpu_rdata     = (state == DONE) ? rsp_data : '0;
  assign cpu_err       = (state == DONE) && rsp_err;

  assign bus_req_valid = (state == REQ);
  assign bus_req_addr  = {req_addr, 2'b00};
  assign bus_req_we    = req_we;
  assign bus_req_wstrb = req_wstrb;
  assign bus_req_wdata = req_wdata;

endmodule
